// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store memory access unit.
package mem_access_pkg;

   localparam int DEF_TIMEOUT = 15;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_REQ   = 3'd1;
   localparam state_t ST_RWAIT = 3'd2;
   localparam state_t ST_WB    = 3'd3;
   localparam state_t ST_ERR   = 3'd4;

   typedef logic [1:0] lane_t;

   function automatic logic [31:0] rep_byte(input logic [7:0] b);
      return {4{b}};
   endfunction

endpackage

// File: rtl/mem_access_lane_fmt.sv
// Byte-lane formatting: store replication, byte enables and load lane extraction.
module lane_fmt
   import mem_access_pkg::*;
(
   input  logic        i_is_byte,
   input  lane_t       i_lane,
   input  logic [31:0] i_str_data,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_ldata
);

   logic [7:0] w_lane_byte;

   // store formatting and load lane select
   always_comb begin
      o_wdata = i_is_byte ? rep_byte(i_str_data[7:0]) : i_str_data;
      o_be    = i_is_byte ? (4'b0001 << i_lane) : 4'b1111;
      case (i_lane)
         2'd0:    w_lane_byte = i_rdata[7:0];
         2'd1:    w_lane_byte = i_rdata[15:8];
         2'd2:    w_lane_byte = i_rdata[23:16];
         2'd3:    w_lane_byte = i_rdata[31:24];
         default: w_lane_byte = 8'h00;
      endcase
      o_ldata = i_is_byte ? {24'h000000, w_lane_byte} : i_rdata;
   end

endmodule

// File: rtl/mem_access.sv
// Single-access load/store sequencer between the CPU controller and data memory,
// with alignment check, bounded handshake waits and load writeback.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int MEM_AW  = 11,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              is_load,
   input  logic              is_byte,
   input  logic [31:0]       addr,
   input  logic [31:0]       str_data,
   input  logic [3:0]        rd_addr,
   output logic              mem_req,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   input  logic              mem_rdy,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       w_data_ldr,
   output logic [3:0]        w_addr_ldr,
   output logic              w_en_ldr,
   output logic              busy,
   output logic              done,
   output logic              abort
);

   localparam int CW = $clog2(TIMEOUT + 1);

   state_t            r_state;
   logic [MEM_AW+1:0] r_addr;
   logic [31:0]       r_str_data;
   logic [3:0]        r_rd_addr;
   logic              r_is_load;
   logic              r_is_byte;
   logic [CW-1:0]     r_cnt;
   logic [31:0]       r_ldata;

   state_t            w_state_nxt;
   logic [CW-1:0]     w_cnt_nxt;
   logic [CW-1:0]     w_cnt_inc;
   logic              w_expired;
   logic              w_misalign;
   logic [31:0]       w_wdata;
   logic [3:0]        w_be;
   logic [31:0]       w_ldata;
   logic              w_unused_addr;

   // only the word-address bits reach memory; the rest wrap around
   assign w_unused_addr = ^addr[31:MEM_AW+2];
   assign w_misalign    = ~is_byte & (addr[1:0] != 2'b00);

   lane_fmt u_lane_fmt (
      .i_is_byte  (r_is_byte),
      .i_lane     (r_addr[1:0]),
      .i_str_data (r_str_data),
      .i_rdata    (mem_rdata),
      .o_wdata    (w_wdata),
      .o_be       (w_be),
      .o_ldata    (w_ldata)
   );

   // next state and saturating wait counter
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_inc   = (r_cnt == CW'(TIMEOUT)) ? r_cnt : r_cnt + CW'(1);
      w_cnt_nxt   = r_cnt;
      w_expired   = (r_cnt >= CW'(TIMEOUT - 1));
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = w_misalign ? ST_ERR : ST_REQ;
               w_cnt_nxt   = {CW{1'b0}};
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (mem_rdy) begin
               w_state_nxt = r_is_load ? ST_RWAIT : ST_IDLE;
               w_cnt_nxt   = {CW{1'b0}};
            end else if (w_expired) begin
               w_state_nxt = ST_ERR;
               w_cnt_nxt   = w_cnt_inc;
            end else begin
               w_cnt_nxt   = w_cnt_inc;
            end
         end
         ST_RWAIT: begin
            if (mem_rvalid) begin
               w_state_nxt = ST_WB;
            end else if (w_expired) begin
               w_state_nxt = ST_ERR;
               w_cnt_nxt   = w_cnt_inc;
            end else begin
               w_cnt_nxt   = w_cnt_inc;
            end
         end
         ST_WB:   w_state_nxt = ST_IDLE;
         ST_ERR:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // state, request latch and load capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_addr     <= '0;
         r_str_data <= 32'h0000_0000;
         r_rd_addr  <= 4'h0;
         r_is_load  <= 1'b0;
         r_is_byte  <= 1'b0;
         r_cnt      <= {CW{1'b0}};
         r_ldata    <= 32'h0000_0000;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (r_state == ST_IDLE && start) begin
            r_addr     <= addr[MEM_AW+1:0];
            r_str_data <= str_data;
            r_rd_addr  <= rd_addr;
            r_is_load  <= is_load;
            r_is_byte  <= is_byte;
         end
         if (r_state == ST_RWAIT && mem_rvalid) begin
            r_ldata <= w_ldata;
         end
      end
   end

   assign busy       = (r_state != ST_IDLE);
   assign mem_req    = (r_state == ST_REQ);
   assign mem_we     = mem_req & ~r_is_load;
   assign mem_be     = mem_req ? w_be : 4'b0000;
   assign mem_addr   = r_addr[MEM_AW+1:2];
   assign mem_wdata  = w_wdata;
   assign w_en_ldr   = (r_state == ST_WB);
   assign w_data_ldr = r_ldata;
   assign w_addr_ldr = r_rd_addr;
   assign abort      = (r_state == ST_ERR);
   // a store completes in its acceptance cycle
   assign done       = (mem_req & mem_rdy & ~r_is_load) | w_en_ldr | abort;

endmodule

// File: tb/tb_mem_access.sv
// Randomized and directed bench for mem_access against a transaction-level model.
module tb_mem_access;

   localparam int MEM_AW  = 11;
   localparam int TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start, is_load, is_byte;
   logic [31:0]       addr, str_data;
   logic [3:0]        rd_addr;
   logic              mem_req, mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_be;
   logic              mem_rdy, mem_rvalid;
   logic [31:0]       mem_rdata;
   logic [31:0]       w_data_ldr;
   logic [3:0]        w_addr_ldr;
   logic              w_en_ldr, busy, done, abort;

   int tests = 0;
   int fails = 0;

   mem_access #(.MEM_AW(MEM_AW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load), .is_byte(is_byte),
      .addr(addr), .str_data(str_data), .rd_addr(rd_addr),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdy(mem_rdy), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .w_data_ldr(w_data_ldr), .w_addr_ldr(w_addr_ldr), .w_en_ldr(w_en_ldr),
      .busy(busy), .done(done), .abort(abort)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // One access; expectations come from the access rules, not the DUT.
   // rdy_dly/rv_dly: REQ/RWAIT cycle index of the handshake, >= TIMEOUT means never.
   task automatic run_access(input bit ld, input bit bt, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] rd,
                             input int rdy_dly, input int rv_dly,
                             input logic [31:0] rdata, input string tag);
      bit                mis;
      bit                hit;
      logic [MEM_AW-1:0] exp_maddr;
      logic [3:0]        exp_be;
      logic [31:0]       exp_wd, exp_ld;
      logic [9:0]        got, want;
      mis       = !bt && (a % 4 != 0);
      exp_maddr = MEM_AW'((a / 4) % (1 << MEM_AW));
      exp_be    = bt ? 4'(1 << (a % 4)) : 4'hF;
      exp_wd    = bt ? (d & 32'hFF) * 32'h0101_0101 : d;
      exp_ld    = bt ? ((rdata >> (8 * (a % 4))) & 32'hFF) : rdata;

      start = 1'b1; is_load = ld; is_byte = bt; addr = a; str_data = d; rd_addr = rd;
      mem_rdy = 1'b0; mem_rvalid = 1'b0;
      cyc();
      start = 1'b0; addr = $urandom; str_data = $urandom; rd_addr = 4'($urandom);
      is_load = 1'($urandom); is_byte = 1'($urandom);
      if (mis) begin
         #1;
         tests++;
         if ({mem_req, abort, done, w_en_ldr, busy} !== 5'b01101) begin
            fails++;
            $display("FAIL %s misalign_err: got req/abort/done/wen/busy=%b want 01101", tag,
                     {mem_req, abort, done, w_en_ldr, busy});
         end
         cyc(); #1;
         tests++;
         if ({busy, abort, done} !== 3'b000) begin
            fails++;
            $display("FAIL %s misalign_idle: got busy/abort/done=%b want 000", tag, {busy, abort, done});
         end
         return;
      end

      hit = 1'b0;
      for (int k = 0; k < TIMEOUT && !hit; k++) begin
         mem_rdy    = (k == rdy_dly);
         mem_rvalid = 1'($urandom);
         mem_rdata  = $urandom;
         #1;
         got  = {mem_req, mem_we, mem_be, done, abort, w_en_ldr, busy};
         want = {1'b1, ~ld, exp_be, (k == rdy_dly) && !ld, 1'b0, 1'b0, 1'b1};
         tests++;
         if (got !== want) begin
            fails++;
            $display("FAIL %s req_ctrl k=%0d: got %b want %b", tag, k, got, want);
         end
         tests++;
         if (mem_addr !== exp_maddr || (!ld && mem_wdata !== exp_wd)) begin
            fails++;
            $display("FAIL %s req_data k=%0d: got addr=%h wdata=%h want addr=%h wdata=%h",
                     tag, k, mem_addr, mem_wdata, exp_maddr, exp_wd);
         end
         hit = (k == rdy_dly);
         cyc();
         mem_rdy = 1'b0; mem_rvalid = 1'b0;
      end

      if (!hit || (ld && rv_dly >= TIMEOUT)) begin
         if (hit) begin
            for (int k = 0; k < TIMEOUT; k++) cyc();
         end
         #1;
         tests++;
         if ({mem_req, abort, done, w_en_ldr, busy} !== 5'b01101) begin
            fails++;
            $display("FAIL %s timeout_err: got req/abort/done/wen/busy=%b want 01101", tag,
                     {mem_req, abort, done, w_en_ldr, busy});
         end
         cyc(); #1;
         tests++;
         if ({busy, abort, done, w_en_ldr} !== 4'b0000) begin
            fails++;
            $display("FAIL %s timeout_idle: got busy/abort/done/wen=%b want 0000", tag,
                     {busy, abort, done, w_en_ldr});
         end
         return;
      end

      if (ld) begin
         for (int k = 0; k <= rv_dly; k++) begin
            mem_rvalid = (k == rv_dly);
            mem_rdata  = (k == rv_dly) ? rdata : $urandom;
            #1;
            tests++;
            if ({mem_req, done, abort, w_en_ldr, busy} !== 5'b00001) begin
               fails++;
               $display("FAIL %s rwait k=%0d: got req/done/abort/wen/busy=%b want 00001", tag, k,
                        {mem_req, done, abort, w_en_ldr, busy});
            end
            cyc();
            mem_rvalid = 1'b0;
         end
         mem_rdata = $urandom;
         #1;
         tests++;
         if ({w_en_ldr, done, abort} !== 3'b110 || w_data_ldr !== exp_ld || w_addr_ldr !== rd) begin
            fails++;
            $display("FAIL %s writeback: got wen/done/abort=%b data=%h rd=%0d want 110 data=%h rd=%0d",
                     tag, {w_en_ldr, done, abort}, w_data_ldr, w_addr_ldr, exp_ld, rd);
         end
         cyc();
      end
      #1;
      tests++;
      if ({busy, done, w_en_ldr, mem_req} !== 4'b0000) begin
         fails++;
         $display("FAIL %s end_idle: got busy/done/wen/req=%b want 0000", tag,
                  {busy, done, w_en_ldr, mem_req});
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; is_load = 1'b0; is_byte = 1'b0; addr = 32'h0;
      str_data = 32'h0; rd_addr = 4'h0; mem_rdy = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      cyc(); cyc(); #1;
      tests++;
      if ({mem_req, mem_we, mem_be, busy, done, abort, w_en_ldr} !== 10'b0 ||
          mem_addr !== '0 || mem_wdata !== 32'h0 || w_data_ldr !== 32'h0 || w_addr_ldr !== 4'h0) begin
         fails++;
         $display("FAIL reset_values: got ctrl=%b addr=%h wdata=%h ldr=%h rd=%h want all 0",
                  {mem_req, mem_we, mem_be, busy, done, abort, w_en_ldr},
                  mem_addr, mem_wdata, w_data_ldr, w_addr_ldr);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      run_access(1'b0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'd0, 2, 0, 32'h0, "word_str");
      run_access(1'b1, 1'b1, 32'h0000_0013, 32'h0, 4'd5, 0, 0, 32'hAABB_CCDD, "byte_ldr");
      run_access(1'b0, 1'b1, 32'h0000_0021, 32'h1234_5678, 4'd0, 0, 0, 32'h0, "byte_str");
      run_access(1'b1, 1'b0, 32'h0000_0006, 32'h0, 4'd2, 0, 0, 32'h0, "misalign_ldr");
      run_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'd3, TIMEOUT, 0, 32'h0, "rdy_timeout");
      run_access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'd4, 0, TIMEOUT, 32'h0, "rv_timeout");
      run_access(1'b0, 1'b0, 32'h0000_0048, 32'h0BAD_F00D, 4'd0, TIMEOUT - 1, 0, 32'h0, "rdy_last");
      run_access(1'b1, 1'b0, 32'hFFFF_E010, 32'h0, 4'd7, 1, TIMEOUT - 1, 32'h1357_9BDF, "wrap_rv_last");
   endtask

   task automatic test_reset_mid();
      start = 1'b1; is_load = 1'b1; is_byte = 1'b0; addr = 32'h0000_0040; rd_addr = 4'd9;
      mem_rdy = 1'b0; mem_rvalid = 1'b0;
      cyc();
      start = 1'b1; is_load = 1'b0; addr = 32'h0000_0080;
      cyc();
      start = 1'b0; #1;
      tests++;
      if (mem_addr !== 11'h010 || mem_req !== 1'b1 || mem_we !== 1'b0) begin
         fails++;
         $display("FAIL start_ignored: got addr=%h req=%b we=%b want 010 1 0", mem_addr, mem_req, mem_we);
      end
      mem_rdy = 1'b1;
      cyc();
      mem_rdy = 1'b0; #1;
      rst_n = 1'b0; #1;
      tests++;
      if ({busy, mem_req, done, abort, w_en_ldr} !== 5'b0 || w_addr_ldr !== 4'h0) begin
         fails++;
         $display("FAIL mid_reset: got busy/req/done/abort/wen=%b rd=%h want 00000 0",
                  {busy, mem_req, done, abort, w_en_ldr}, w_addr_ldr);
      end
      cyc();
      rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
      cyc();
      mem_rvalid = 1'b0; #1;
      tests++;
      if ({busy, done, abort, w_en_ldr} !== 4'b0000 || w_data_ldr !== 32'h0) begin
         fails++;
         $display("FAIL late_rvalid: got busy/done/abort/wen=%b data=%h want 0000 0",
                  {busy, done, abort, w_en_ldr}, w_data_ldr);
      end
   endtask

   task automatic test_random();
      bit          ld, bt;
      logic [31:0] a;
      int          rdy, rv;
      for (int n = 0; n < 40; n++) begin
         ld = 1'($urandom); bt = 1'($urandom); a = $urandom;
         if (!bt && ($urandom % 8 != 0)) a[1:0] = 2'b00;
         rdy = $urandom_range(0, 4);
         rv  = $urandom_range(0, 4);
         if ($urandom % 10 == 0) rdy = TIMEOUT;
         if ($urandom % 10 == 0) rv = TIMEOUT;
         run_access(ld, bt, a, $urandom, 4'($urandom), rdy, rv, $urandom, "rand");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
